bn_requant_stage: RTL and testbench

//  Streaming per-channel batch-norm / requantisation stage sitting directly upstream of HSwish.

---
 rtl/bn_requant_stage.sv | 135 +++++++++++++
 tb/tb_bn_requant_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bn_requant_stage.sv
// Per-channel batch-norm / requantisation stage: scales wide conv accumulators by a Q8.8
// coefficient, adds a Q8.8 bias, then rounds and saturates to Q8.8 for the HSwish stage.
module bn_requant_stage #(
    parameter int ACC_W  = 32,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int NUM_CH = 16,
    parameter int CH_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_first,
    input  logic [ACC_W-1:0]  in_acc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_addr,
    input  logic [DATA_W-1:0] cfg_scale,
    input  logic [DATA_W-1:0] cfg_bias,
    output logic [15:0]       sat_count
);

    localparam int PROD_W = ACC_W + DATA_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam logic signed [SUM_W-1:0] RND_HALF = SUM_W'(1) <<< (2*FRAC_W-1);
    localparam logic signed [SUM_W-1:0] SAT_MAX  = (SUM_W'(1) <<< (DATA_W-1)) - SUM_W'(1);
    localparam logic signed [SUM_W-1:0] SAT_MIN  = -(SUM_W'(1) <<< (DATA_W-1));

    logic adv;
    logic accept;
    logic [CH_W-1:0] ch_cnt;
    logic [CH_W-1:0] ch_sel;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;
    assign ch_sel   = in_first ? '0 : ch_cnt;

    // Coefficient tables: no reset, software reloads them after reset.
    logic [DATA_W-1:0] scale_mem [NUM_CH];
    logic [DATA_W-1:0] bias_mem  [NUM_CH];

    logic signed [ACC_W-1:0]  s1_acc;
    logic signed [DATA_W-1:0] s1_scale;
    logic signed [DATA_W-1:0] s1_bias;
    logic [CH_W-1:0]          s1_ch;
    logic                     s1_valid;

    logic signed [SUM_W-1:0]  s2_sum;
    logic [CH_W-1:0]          s2_ch;
    logic                     s2_valid;

    // Registered read returns the pre-write value when a write hits the same channel.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            scale_mem[cfg_addr] <= cfg_scale;
            bias_mem[cfg_addr]  <= cfg_bias;
        end
        if (adv) begin
            s1_scale <= signed'(scale_mem[ch_sel]);
            s1_bias  <= signed'(bias_mem[ch_sel]);
        end
    end

    logic signed [PROD_W-1:0] s2_prod;
    logic signed [SUM_W-1:0]  s2_bias_ext;
    logic signed [SUM_W-1:0]  s2_sum_next;

    assign s2_prod     = PROD_W'(s1_acc) * PROD_W'(s1_scale);
    assign s2_bias_ext = SUM_W'(s1_bias) <<< (2*FRAC_W);
    assign s2_sum_next = SUM_W'(s2_prod) + s2_bias_ext;

    logic signed [SUM_W-1:0]  s3_rounded;
    logic signed [SUM_W-1:0]  s3_shifted;
    logic [DATA_W-1:0]        s3_result;
    logic                     s3_clamped;

    assign s3_rounded = s2_sum + RND_HALF;
    assign s3_shifted = s3_rounded >>> (2*FRAC_W);

    always_comb begin
        s3_result  = s3_shifted[DATA_W-1:0];
        s3_clamped = 1'b0;
        if (s3_shifted > SAT_MAX) begin
            s3_result  = {1'b0, {(DATA_W-1){1'b1}}};
            s3_clamped = 1'b1;
        end else if (s3_shifted < SAT_MIN) begin
            s3_result  = {1'b1, {(DATA_W-1){1'b0}}};
            s3_clamped = 1'b1;
        end
    end

    // Datapath registers carry no reset; the valid bits below qualify them.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_acc <= signed'(in_acc);
            s1_ch  <= ch_sel;
            s2_sum <= s2_sum_next;
            s2_ch  <= s1_ch;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_cnt    <= '0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            sat_count <= '0;
        end else begin
            if (accept) begin
                ch_cnt <= (ch_sel == CH_W'(NUM_CH-1)) ? '0 : ch_sel + 1'b1;
            end
            if (adv) begin
                s1_valid  <= in_valid;
                s2_valid  <= s1_valid;
                out_valid <= s2_valid;
                if (s2_valid) begin
                    out_data <= s3_result;
                    out_ch   <= s2_ch;
                    if (s3_clamped && sat_count != 16'hFFFF) begin
                        sat_count <= sat_count + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bn_requant_stage.sv
// Directed bench for bn_requant_stage: coefficient vectors, rounding/saturation edges,
// random backpressure ordering, config/read collision and mid-stream reset.
module tb_bn_requant_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_first;
    logic [31:0] in_acc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_ch;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_scale;
    logic [15:0] cfg_bias;
    logic [15:0] sat_count;

    int checks = 0;
    int errors = 0;

    bn_requant_stage #(
        .ACC_W(32), .DATA_W(16), .FRAC_W(8), .NUM_CH(16), .CH_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_acc(in_acc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_scale(cfg_scale), .cfg_bias(cfg_bias),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] scale;
        logic [15:0] bias;
        logic [31:0] acc;
        logic [15:0] exp_data;
        logic [15:0] exp_sat;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [15:0] scale, input logic [15:0] bias);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = addr; cfg_scale = scale; cfg_bias = bias;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // One isolated beat through an empty pipeline; expects out_valid on the third edge.
    task automatic send_one(input logic [31:0] acc, input logic first,
                            input logic [15:0] exp_d, input logic [3:0] exp_c, input string name);
        int n;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_first = first; in_acc = acc;
        @(negedge clk);
        in_valid = 1'b0; in_first = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        $display("beat %s acc=%h out_valid=%0d out_data=%h out_ch=%0d latency=%0d",
                 name, acc, out_valid, out_data, out_ch, n);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_latency"}, 32'(n), 32'd3);
        check({name, "_data"}, 32'(out_data), 32'(exp_d));
        check({name, "_ch"}, 32'(out_ch), 32'(exp_c));
    endtask

    initial begin
        int sent, got, stale;
        logic hold;
        logic [15:0] held_d;
        logic [3:0]  held_c;
        logic [15:0] got_d [2];

        vecs[0]  = '{16'h0100, 16'h0000, 32'h00030000, 16'h0300, 16'd0};
        vecs[1]  = '{16'h0100, 16'h0080, 32'h00030000, 16'h0380, 16'd0};
        vecs[2]  = '{16'h0100, 16'h0000, 32'hFFFF0000, 16'hFF00, 16'd0};
        vecs[3]  = '{16'h0100, 16'h0000, 32'h00000080, 16'h0001, 16'd0};
        vecs[4]  = '{16'h0100, 16'h0000, 32'h0000007F, 16'h0000, 16'd0};
        vecs[5]  = '{16'h0100, 16'h0000, 32'hFFFFFF80, 16'h0000, 16'd0};
        vecs[6]  = '{16'h0100, 16'h0000, 32'hFFFFFF7F, 16'hFFFF, 16'd0};
        vecs[7]  = '{16'hFF00, 16'h0100, 32'h00028000, 16'hFE80, 16'd0};
        vecs[8]  = '{16'h0100, 16'h0000, 32'h007FFF00, 16'h7FFF, 16'd0};
        vecs[9]  = '{16'h0100, 16'h0000, 32'hFF800000, 16'h8000, 16'd0};
        vecs[10] = '{16'h0200, 16'h0000, 32'h7FFF0000, 16'h7FFF, 16'd1};
        vecs[11] = '{16'h0200, 16'h0000, 32'h80010000, 16'h8000, 16'd2};
        vecs[12] = '{16'h0100, 16'h0000, 32'h00800000, 16'h7FFF, 16'd3};

        rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_acc = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_scale = '0; cfg_bias = '0;
        repeat (3) @(negedge clk);
        $display("reset out_valid=%0d out_data=%h out_ch=%0d sat_count=%0d in_ready=%0d",
                 out_valid, out_data, out_ch, sat_count, in_ready);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        check("rst_sat_count", 32'(sat_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cfg_write(4'd0, vecs[i].scale, vecs[i].bias);
            send_one(vecs[i].acc, 1'b1, vecs[i].exp_data, 4'd0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_sat", i), 32'(sat_count), 32'(vecs[i].exp_sat));
        end

        // Same-cycle write and read of channel 0: first beat sees the old scale.
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_scale = 16'h0200; cfg_bias = 16'h0000;
        in_valid = 1'b1; in_first = 1'b1; in_acc = 32'h00010000; out_ready = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_first = 1'b0;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid && got < 2) begin
                got_d[got] = out_data;
                $display("collision beat %0d out_data=%h", got, out_data);
                got++;
            end
            @(negedge clk);
        end
        check("coll_count", 32'(got), 32'd2);
        check("coll_old", 32'(got_d[0]), 32'h0100);
        check("coll_new", 32'(got_d[1]), 32'h0200);

        for (int c = 0; c < 16; c++) begin
            cfg_write(4'(c), 16'h0100, 16'(c << 8));
        end

        // Back-to-back stream with random output stalls.
        sent = 0; got = 0; hold = 1'b0; held_d = '0; held_c = '0;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 20) begin
                in_valid = 1'b1; in_first = (sent == 0); in_acc = 32'(sent) << 16;
            end else begin
                in_valid = 1'b0; in_first = 1'b0;
            end
            #1;
            if (hold) begin
                check("bp_hold_valid", 32'(out_valid), 32'd1);
                check("bp_hold_data", 32'(out_data), 32'(held_d));
                check("bp_hold_ch", 32'(out_ch), 32'(held_c));
            end
            if (out_valid && out_ready) begin
                $display("stream beat %0d out_data=%h out_ch=%0d", got, out_data, out_ch);
                check($sformatf("bp_data%0d", got), 32'(out_data), 32'(((got + got % 16) << 8) & 16'hFFFF));
                check($sformatf("bp_ch%0d", got), 32'(out_ch), 32'(got % 16));
                got++;
            end
            hold = out_valid && !out_ready;
            held_d = out_data; held_c = out_ch;
            if (in_valid && in_ready) sent++;
        end
        check("bp_count", 32'(got), 32'd20);

        // Reset with beats in flight.
        @(negedge clk);
        in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_first = (k == 0); in_acc = 32'h00050000;
        end
        @(negedge clk);
        in_valid = 1'b0; in_first = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        $display("midreset out_valid=%0d sat_count=%0d out_data=%h", out_valid, sat_count, out_data);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_sat_count", 32'(sat_count), 32'd0);
        check("mrst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("mrst_no_stale", 32'(stale), 32'd0);

        // Table survives reset; counter restarts at 0 and in_first resyncs it.
        send_one(32'h00010000, 1'b0, 16'h0100, 4'd0, "post0");
        send_one(32'h00010000, 1'b0, 16'h0200, 4'd1, "post1");
        send_one(32'h00010000, 1'b1, 16'h0100, 4'd0, "resync");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
